// File: rtl/vga_compositor.sv
// Two-stage pixel compositor: cursor sprite, slot borders with blinking highlight,
// scaled drawing canvas and per-slot prediction characters, fed by synchronous ROMs/RAM.
module vga_compositor #(
    parameter int unsigned N_SLOTS      = 5,
    parameter int unsigned LEFT         = 255,
    parameter int unsigned TOP          = 225,
    parameter int unsigned IMG          = 28,
    parameter int unsigned BORDER       = 4,
    parameter int unsigned CHAR_Y       = 208,
    parameter int unsigned CANVAS_X     = 64,
    parameter int unsigned CANVAS_Y     = 64,
    parameter int unsigned CANVAS_SHIFT = 2,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned IDX_W       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     pix_en,
    input  logic                     blank,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [9:0]               MOUSE_X,
    input  logic [9:0]               MOUSE_Y,
    input  logic [1:0]               MOUSE_MODE,
    input  logic [N_SLOTS-1:0][31:0] NN_CODE_REGS,
    input  logic                     HILITE_EN,
    input  logic [IDX_W-1:0]         HILITE_IDX,
    output logic                     MEM_RE,
    output logic [10:0]              FONT_ADDR,
    input  logic [7:0]               FONT_DATA,
    output logic [7:0]               CURSOR_ADDR,
    input  logic [2:0]               CURSOR_DATA,
    output logic [4:0]               CANVAS_ADDR,
    input  logic [31:0]              CANVAS_ROW,
    output logic [3:0]               RED,
    output logic [3:0]               GREEN,
    output logic [3:0]               BLUE
);

    localparam int unsigned PITCH       = IMG + BORDER;
    localparam int unsigned SLOT_END    = LEFT + N_SLOTS * PITCH;
    localparam int unsigned CANVAS_SIZE = 28 << CANVAS_SHIFT;
    localparam int unsigned FC_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Stage 0 combinational results
    int unsigned px, py, mx, my, hidx, slot_x, cdx, cdy;
    logic        vband, hband, cband, hilite_ok;
    logic        cursor_0, border_0, hilite_0, canvas_0, char_0;
    logic [4:0]  canvas_col_0;
    logic [2:0]  char_col_0;
    logic [31:0] code;
    logic [6:0]  font_code;

    // Stage 1 registers
    logic        blank_s1, cursor_s1, border_s1, hilite_s1, canvas_s1, char_s1;
    logic [4:0]  canvas_col_s1;
    logic [2:0]  char_col_s1;
    logic [1:0]  mode_s1;

    logic [FC_W-1:0] frame_cnt_q;
    logic            phase_q;
    logic [11:0]     rgb_d, rgb_q;

    assign MEM_RE = pix_en;

    always_comb begin
        px   = 32'(DrawX);
        py   = 32'(DrawY);
        mx   = 32'(MOUSE_X);
        my   = 32'(MOUSE_Y);
        hidx = 32'(HILITE_IDX);

        // Cursor rows sit above the hotspot; the +16 offsets avoid underflow near y=0
        cursor_0    = (mx <= px) && (px < mx + 16) && (my < py + 16) && (py + 16 <= my + 15);
        cdx         = px - mx;
        cdy         = py + 15 - my;
        CURSOR_ADDR = 8'(cdx + (cdy << 4));

        canvas_0     = (px >= CANVAS_X) && (px < CANVAS_X + CANVAS_SIZE) &&
                       (py >= CANVAS_Y) && (py < CANVAS_Y + CANVAS_SIZE);
        canvas_col_0 = 5'((px - CANVAS_X) >> CANVAS_SHIFT);
        CANVAS_ADDR  = canvas_0 ? 5'((py - CANVAS_Y) >> CANVAS_SHIFT) : 5'd0;

        vband     = (py + BORDER >= TOP) && (py < TOP + IMG + BORDER);
        hband     = vband && ((py < TOP) || (py >= TOP + IMG));
        cband     = (py >= CHAR_Y) && (py < CHAR_Y + 16);
        hilite_ok = HILITE_EN && (hidx < N_SLOTS);

        border_0   = hband && (px + BORDER >= LEFT) && (px < SLOT_END);
        hilite_0   = 1'b0;
        char_0     = 1'b0;
        char_col_0 = 3'd0;
        code       = 32'd0;
        slot_x     = LEFT;
        for (int unsigned j = 0; j <= N_SLOTS; j++) begin
            slot_x = LEFT + j * PITCH;
            if (vband && (px + BORDER > slot_x) && (px <= slot_x)) begin
                border_0 = 1'b1;
                if (hilite_ok && (j == hidx || j == hidx + 1)) hilite_0 = 1'b1;
            end
            if (j < N_SLOTS) begin
                if (hband && hilite_ok && (j == hidx) &&
                    (px + BORDER > slot_x) && (px <= slot_x + PITCH)) begin
                    hilite_0 = 1'b1;
                end
                if (cband && (px > slot_x) && (px <= slot_x + 8)) begin
                    char_0     = 1'b1;
                    char_col_0 = 3'(px - slot_x - 1);
                    code       = NN_CODE_REGS[IDX_W'(j)];
                end
            end
        end

        font_code = (code > 32'd127) ? 7'h3F : code[6:0];
        FONT_ADDR = {font_code, DrawY[3:0]};
    end

    always_comb begin
        rgb_d = 12'h000;
        if (!blank_s1) begin
            rgb_d = 12'h000;
        end else if (cursor_s1 && (CURSOR_DATA != 3'd0)) begin
            case (CURSOR_DATA)
                3'd1:    rgb_d = 12'h000;
                3'd2:    rgb_d = (mode_s1 == 2'b10) ? 12'hFAC : 12'hFD0;
                3'd3:    rgb_d = 12'h666;
                3'd4:    rgb_d = 12'hBBB;
                3'd5:    rgb_d = 12'hFEC;
                3'd6:    rgb_d = 12'hFAC;
                3'd7:    rgb_d = 12'h974;
                default: rgb_d = 12'h000;
            endcase
        end else if (border_s1) begin
            rgb_d = (hilite_s1 && phase_q) ? 12'h0F0 : 12'hF00;
        end else if (canvas_s1 && CANVAS_ROW[canvas_col_s1]) begin
            rgb_d = 12'hFFF;
        end else if (char_s1 && FONT_DATA[3'd7 - char_col_s1]) begin
            rgb_d = 12'hFFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            blank_s1      <= 1'b0;
            cursor_s1     <= 1'b0;
            border_s1     <= 1'b0;
            hilite_s1     <= 1'b0;
            canvas_s1     <= 1'b0;
            char_s1       <= 1'b0;
            canvas_col_s1 <= 5'd0;
            char_col_s1   <= 3'd0;
            mode_s1       <= 2'd0;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b0;
            rgb_q         <= 12'h000;
        end else if (pix_en) begin
            blank_s1      <= blank;
            cursor_s1     <= cursor_0;
            border_s1     <= border_0;
            hilite_s1     <= hilite_0;
            canvas_s1     <= canvas_0;
            char_s1       <= char_0;
            canvas_col_s1 <= canvas_col_0;
            char_col_s1   <= char_col_0;
            mode_s1       <= MOUSE_MODE;
            rgb_q         <= rgb_d;
            if ((DrawX == 10'd0) && (DrawY == 10'd0)) begin
                if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    assign RED   = rgb_q[11:8];
    assign GREEN = rgb_q[7:4];
    assign BLUE  = rgb_q[3:0];

endmodule
